axis_frame_summarizer: RTL and testbench

Stream sink that sits directly downstream of the 4096-deep FIFO's AXI-stream master port (m_data/m_valid/m_ready/m_last). It consumes 32-bit beats and accumulates a per-frame beat count and a modulo-2^32 word sum, where a frame is delimited by the last flag. For each frame it emits one summary record over a valid/ready handshake, and it applies backpressure to the FIFO while a record is pending.

---
 rtl/axis_frame_summarizer.sv | 94 +++++++++
 tb/tb_axis_frame_summarizer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_summarizer.sv
// AXI-stream frame sink: accumulates beat count and word sum per frame and
// emits one summary record per frame, stalling the stream while it is pending.
module axis_frame_summarizer #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4096,
  localparam int LEN_W    = $clog2(MAX_BEATS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] sum_data,
  output logic [LEN_W-1:0]  sum_len,
  output logic              sum_err,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [15:0]       frame_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  state_t            state;
  logic [DATA_W-1:0] acc_sum;
  logic [LEN_W-1:0]  acc_len;
  logic              acc_err;

  logic              beat;
  logic              full;
  logic [DATA_W-1:0] nxt_sum;
  logic [LEN_W-1:0]  nxt_len;
  logic              nxt_err;

  // Accumulator values including the beat presented this cycle.
  always_comb begin
    beat    = s_valid && s_ready;
    full    = (acc_len == MAX_LEN);
    nxt_sum = acc_sum + s_data;
    nxt_len = full ? acc_len : acc_len + LEN_W'(1);
    nxt_err = acc_err || full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      s_ready   <= 1'b0;
      acc_sum   <= '0;
      acc_len   <= '0;
      acc_err   <= 1'b0;
      sum_data  <= '0;
      sum_len   <= '0;
      sum_err   <= 1'b0;
      sum_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ACCUM: begin
          // s_ready comes out of reset low and rises on the first edge here.
          s_ready <= 1'b1;
          if (beat) begin
            if (s_last) begin
              sum_data  <= nxt_sum;
              sum_len   <= nxt_len;
              sum_err   <= nxt_err;
              sum_valid <= 1'b1;
              acc_sum   <= '0;
              acc_len   <= '0;
              acc_err   <= 1'b0;
              s_ready   <= 1'b0;
              state     <= HOLD;
            end else begin
              acc_sum <= nxt_sum;
              acc_len <= nxt_len;
              acc_err <= nxt_err;
            end
          end
        end
        HOLD: begin
          if (sum_valid && sum_ready) begin
            sum_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            s_ready   <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_summarizer.sv
// Bench for axis_frame_summarizer: directed and random frames against a
// queue-based model of each frame's sum, length and overflow flag.
module tb_axis_frame_summarizer;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4096;
  localparam int LEN_W     = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [DATA_W-1:0] sum_data;
  logic [LEN_W-1:0]  sum_len;
  logic              sum_err;
  logic              sum_valid;
  logic              sum_ready;
  logic [15:0]       frame_cnt;

  int              errors  = 0;
  int              checks  = 0;
  int unsigned     exp_cnt = 0;
  int unsigned     gap_pct = 0;
  logic [31:0]     beats[$];
  logic [31:0]     last_sum;

  axis_frame_summarizer #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .sum_data(sum_data), .sum_len(sum_len), .sum_err(sum_err),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (s_ready !== 1'b1 && c < 50) begin
      tick;
      c++;
    end
    if (c >= 50) chk(tag, {63'd0, s_ready}, 64'd1);
  endtask

  // Drives the queued beats, with optional idle gaps carrying junk s_last.
  task automatic send_frame(input bit ends);
    for (int i = 0; i < beats.size(); i++) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_last  = 1'($urandom);
        s_data  = $urandom;
        tick;
      end
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = ends && (i == beats.size() - 1);
      wait_ready("beat_ready_timeout");
      tick;
    end
  endtask

  // Checks the record right after the last beat, stalls, then hands it off.
  task automatic check_record(input int stall);
    logic [31:0] e_sum = '0;
    int unsigned n = beats.size();
    int unsigned e_len = (n > MAX_BEATS) ? MAX_BEATS : n;
    logic e_err = (n > MAX_BEATS);
    foreach (beats[i]) e_sum += beats[i];
    s_valid = 1'b1;
    s_data  = $urandom;
    s_last  = 1'($urandom);
    chk("rec_valid", {63'd0, sum_valid}, 64'd1);
    chk("rec_sready_low", {63'd0, s_ready}, 64'd0);
    chk("rec_data", {32'd0, sum_data}, {32'd0, e_sum});
    chk("rec_len", {51'd0, sum_len}, 64'(e_len));
    chk("rec_err", {63'd0, sum_err}, {63'd0, e_err});
    for (int k = 0; k < stall; k++) begin
      sum_ready = 1'b0;
      tick;
      chk("stall_valid", {63'd0, sum_valid}, 64'd1);
      chk("stall_sready", {63'd0, s_ready}, 64'd0);
      chk("stall_data", {32'd0, sum_data}, {32'd0, e_sum});
      chk("stall_len", {51'd0, sum_len}, 64'(e_len));
    end
    sum_ready = 1'b1;
    tick;
    exp_cnt++;
    chk("hs_valid_clear", {63'd0, sum_valid}, 64'd0);
    chk("hs_sready_back", {63'd0, s_ready}, 64'd1);
    chk("hs_frame_cnt", {48'd0, frame_cnt}, {48'd0, exp_cnt[15:0]});
    sum_ready = 1'b0;
    s_valid   = 1'b0;
    last_sum  = e_sum;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; sum_ready = 1'b0;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("reset_outputs", {s_ready, sum_valid, sum_err, sum_data, sum_len, frame_cnt}, 64'd0);
    end
    rst = 1'b1;
    chk("release_sready_still_low", {63'd0, s_ready}, 64'd0);
    tick;
    chk("release_sready_high", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b0; s_last = 1'b1; s_data = $urandom;
    repeat (3) tick;
    chk("idle_no_record", {63'd0, sum_valid}, 64'd0);
    chk("idle_len_zero", {51'd0, sum_len}, 64'd0);

    // Nominal 40-beat frames of 2,4,6,...
    for (int f = 0; f < 3; f++) begin
      beats.delete();
      for (int k = 0; k < 40; k++) beats.push_back(32'(2 * (40 * f + k + 1)));
      send_frame(1'b1);
      if (f == 0) chk("nominal_f0_sum", {32'd0, sum_data}, 64'd1640);
      if (f == 1) chk("nominal_f1_sum", {32'd0, sum_data}, 64'd4840);
      check_record(0);
    end

    // Backpressure: 1..5 with 10 stalled cycles
    beats = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    send_frame(1'b1);
    chk("bp_sum", {32'd0, sum_data}, 64'd15);
    check_record(10);

    // Wrap-around and single beat
    beats = '{32'hFFFF_FFFF, 32'h0000_0002};
    send_frame(1'b1);
    chk("wrap_sum", {32'd0, sum_data}, 64'd1);
    check_record(1);
    beats = '{32'h0000_00A5};
    send_frame(1'b1);
    check_record(0);

    // Oversize frame then a normal one
    beats.delete();
    for (int k = 0; k < 4100; k++) beats.push_back(32'd1);
    send_frame(1'b1);
    chk("over_sum", {32'd0, sum_data}, 64'd4100);
    check_record(2);
    beats = '{32'd3, 32'd4, 32'd5};
    send_frame(1'b1);
    check_record(0);

    // Randomized frames with idle gaps and random stalls
    gap_pct = 30;
    for (int f = 0; f < 25; f++) begin
      int unsigned len = $urandom_range(1, 64);
      beats.delete();
      for (int k = 0; k < int'(len); k++) beats.push_back($urandom);
      send_frame(1'b1);
      check_record(int'($urandom_range(0, 3)));
    end
    gap_pct = 0;

    // Reset in the middle of a frame
    beats.delete();
    for (int k = 0; k < 20; k++) beats.push_back(32'd9);
    send_frame(1'b0);
    s_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("midreset_async_clear", {s_ready, sum_valid, sum_err, sum_data, sum_len, frame_cnt}, 64'd0);
    tick;
    tick;
    rst = 1'b1;
    exp_cnt = 0;
    tick;
    chk("midreset_sready", {63'd0, s_ready}, 64'd1);
    beats = '{32'd7, 32'd7, 32'd7};
    send_frame(1'b1);
    chk("midreset_sum", {32'd0, sum_data}, 64'd21);
    check_record(0);
    chk("midreset_frame_cnt", {48'd0, frame_cnt}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
